// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: centre-samples RXD, assembles bytes LSB first and holds
// the last byte in a one-deep buffer with valid, overrun and framing-error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 64_000_000,
    parameter int unsigned BIT_RATE = 4_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rxd,
    input  logic       uart_rx_read,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_valid,
    output logic       uart_rx_overrun,
    output logic       uart_rx_frame_err,
    output logic       uart_rx_busy
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT);

    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);

    generate
        if (CYCLES_PER_BIT < 4) begin : g_rate_check
            $error("uart_rx: CLK_HZ/BIT_RATE must be at least 4");
        end
    endgenerate

    logic             rxs;
    logic             tick;
    uart_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             overrun_q;
    logic             frame_err_q;

    // Preset high so a line held low across reset release is not taken as a start bit.
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk   (clk),
        .resetn(resetn),
        .d_i   (uart_rxd),
        .q_o   (rxs)
    );

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // Read clears first; a commit or framing error later in this block takes precedence.
            if (uart_rx_read) begin
                valid_q     <= 1'b0;
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end

            if (!tick) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_q <= START;
                        cnt_q   <= HALF_LOAD;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rxs) begin
                            state_q   <= DATA;
                            cnt_q     <= FULL_LOAD;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= {rxs, shift_q[7:1]};
                        cnt_q   <= FULL_LOAD;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (rxs) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            if (valid_q && !uart_rx_read) begin
                                overrun_q <= 1'b1;
                            end
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign uart_rx_data      = data_q;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_overrun   = overrun_q;
    assign uart_rx_frame_err = frame_err_q;
    assign uart_rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int unsigned n_assert = 0;
    int unsigned n_fail = 0;
    int unsigned lat;
    int unsigned busy_low;
    int unsigned n;
    logic        got;

    logic [7:0]  pat [3] = '{8'h00, 8'hFF, 8'h5A};
    int unsigned bt  [2] = '{1656, 1544};

    uart_rx #(
        .CLK_HZ  (64_000_000),
        .BIT_RATE(4_000_000)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .uart_rxd         (rxd),
        .uart_rx_read     (rd),
        .uart_rx_data     (data),
        .uart_rx_valid    (valid),
        .uart_rx_overrun  (overrun),
        .uart_rx_frame_err(frame_err),
        .uart_rx_busy     (busy)
    );

    always #50 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int unsigned cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned stop_low_bits);
        align();
        rxd = 1'b0;
        wait_cycles(16);
        for (int unsigned i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cycles(16);
        end
        if (stop_low_bits > 0) begin
            rxd = 1'b0;
            wait_cycles(16 * stop_low_bits);
        end
        rxd = 1'b1;
        wait_cycles(16);
    endtask

    task automatic send_skew(input logic [7:0] b, input int unsigned bit_t);
        align();
        rxd = 1'b0;
        #(bit_t);
        for (int unsigned i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bit_t);
        end
        rxd = 1'b1;
        #(bit_t * 3);
    endtask

    task automatic pulse_read();
        align();
        rd = 1'b1;
        wait_cycles(1);
        rd = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk8("reset_data", data, 8'h00);
        chk1("reset_valid", valid, 1'b0);
        chk1("reset_overrun", overrun, 1'b0);
        chk1("reset_frame_err", frame_err, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        @(posedge clk);
        #3 resetn = 1'b1;
        wait_cycles(5);

        // Single byte: latency from start edge to valid, busy held across the frame.
        lat = 0;
        busy_low = 0;
        got = 1'b0;
        fork
            send_byte(8'hA5, 0);
            begin
                align();
                while (!got && lat < 300) begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                    if (valid) got = 1'b1;
                    else if (lat >= 3 && !busy) busy_low++;
                end
            end
        join
        n_assert++;
        assert (got && lat >= 154 && lat <= 156) else begin
            n_fail++;
            $error("FAIL latency: observed %0d cycles (seen=%b) expected 155+-1", lat, got);
        end
        n_assert++;
        assert (busy_low == 0) else begin
            n_fail++;
            $error("FAIL busy_during_frame: observed %0d idle cycles expected 0", busy_low);
        end
        @(negedge clk);
        chk8("a5_data", data, 8'hA5);
        chk1("a5_valid", valid, 1'b1);
        chk1("a5_overrun", overrun, 1'b0);
        chk1("a5_frame_err", frame_err, 1'b0);
        chk1("a5_busy_after", busy, 1'b0);
        pulse_read();
        @(negedge clk);
        chk1("a5_read_valid", valid, 1'b0);

        // Glitch shorter than half a bit.
        align();
        rxd = 1'b0;
        wait_cycles(5);
        rxd = 1'b1;
        @(negedge clk);
        chk1("glitch_seen_busy", busy, 1'b1);
        n = 0;
        while (busy && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk1("glitch_busy_clear", busy, 1'b0);
        wait_cycles(20);
        @(negedge clk);
        chk1("glitch_valid", valid, 1'b0);
        chk1("glitch_frame_err", frame_err, 1'b0);

        // Framing error: stop bit low for two bit times.
        send_byte(8'h3C, 2);
        wait_cycles(20);
        @(negedge clk);
        chk1("frame_err_set", frame_err, 1'b1);
        chk1("frame_valid", valid, 1'b0);
        chk8("frame_data_kept", data, 8'hA5);
        chk1("frame_busy_idle", busy, 1'b0);
        send_byte(8'h81, 0);
        wait_cycles(4);
        @(negedge clk);
        chk8("after_frame_data", data, 8'h81);
        chk1("after_frame_valid", valid, 1'b1);
        chk1("frame_err_sticky", frame_err, 1'b1);
        pulse_read();
        @(negedge clk);
        chk1("frame_err_cleared", frame_err, 1'b0);
        chk1("after_frame_read_valid", valid, 1'b0);

        // Overrun: two bytes without a read.
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        wait_cycles(4);
        @(negedge clk);
        chk8("overrun_data", data, 8'h22);
        chk1("overrun_valid", valid, 1'b1);
        chk1("overrun_flag", overrun, 1'b1);
        pulse_read();
        @(negedge clk);
        chk1("overrun_read_valid", valid, 1'b0);
        chk1("overrun_read_flag", overrun, 1'b0);

        // Read on the exact commit cycle of the second byte (stop tick 155 cycles after start).
        send_byte(8'h44, 0);
        @(negedge clk);
        chk8("coinc_first_data", data, 8'h44);
        chk1("coinc_first_valid", valid, 1'b1);
        fork
            send_byte(8'h55, 0);
            begin
                align();
                wait_cycles(154);
                rd = 1'b1;
                wait_cycles(1);
                rd = 1'b0;
            end
        join
        @(negedge clk);
        chk8("coinc_data", data, 8'h55);
        chk1("coinc_valid", valid, 1'b1);
        chk1("coinc_overrun", overrun, 1'b0);
        pulse_read();

        // Bit period skewed by +3.5% then -3.5%; the last byte is left unread.
        for (int unsigned s = 0; s < 2; s++) begin
            for (int unsigned k = 0; k < 3; k++) begin
                send_skew(pat[k], bt[s]);
                @(negedge clk);
                chk8("skew_data", data, pat[k]);
                chk1("skew_valid", valid, 1'b1);
                chk1("skew_frame_err", frame_err, 1'b0);
                if (!(s == 1 && k == 2)) pulse_read();
            end
        end

        // Asynchronous reset in the middle of a data phase.
        align();
        rxd = 1'b0;
        wait_cycles(16);
        rxd = 1'b1;
        wait_cycles(16);
        rxd = 1'b0;
        wait_cycles(16);
        rxd = 1'b1;
        wait_cycles(10);
        chk1("mid_frame_busy", busy, 1'b1);
        chk8("mid_frame_data", data, 8'h5A);
        #20 resetn = 1'b0;
        #5;
        chk8("async_reset_data", data, 8'h00);
        chk1("async_reset_valid", valid, 1'b0);
        chk1("async_reset_overrun", overrun, 1'b0);
        chk1("async_reset_frame_err", frame_err, 1'b0);
        chk1("async_reset_busy", busy, 1'b0);
        wait_cycles(3);
        #20 resetn = 1'b1;
        wait_cycles(300);
        @(negedge clk);
        chk1("post_reset_valid", valid, 1'b0);
        chk8("post_reset_data", data, 8'h00);
        chk1("post_reset_busy", busy, 1'b0);
        chk1("post_reset_frame_err", frame_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
